// File: rtl/onehot_seq.sv
// onehot_seq: one-hot sequencer with per-state dwell, up/down stepping, load, wrap pulse and illegal-load error pulse; ports ck, r (async active-low), en, dir, load, load_idx -> state, f, wrap, err
module onehot_seq #(
  parameter int N = 4,
  parameter int DWELL = 1,
  localparam int W = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic         ck,
  input  logic         r,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_idx,
  output logic [N-1:0] state,
  output logic [W-1:0] f,
  output logic         wrap,
  output logic         err
);
  localparam logic [W:0] NW = (W+1)'(N);
  localparam logic [W-1:0] TOP = W'(N - 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  logic [CW-1:0] cnt, ncnt;
  logic [W-1:0] nf, step;
  logic nwrap, nerr;
  assign step = dir ? ((f == '0) ? TOP : f - 1'b1) : ((f == TOP) ? '0 : f + 1'b1);
  always_comb begin
    nf = f;
    ncnt = cnt;
    nwrap = 1'b0;
    nerr = 1'b0;
    if (load) begin
      if ({1'b0, load_idx} < NW) begin
        nf = load_idx;
        ncnt = '0;
      end else nerr = 1'b1;
    end else if (en) begin
      if (cnt == LAST) begin
        ncnt = '0;
        nf = step;
        nwrap = dir ? (f == '0) : (f == TOP);
      end else ncnt = cnt + 1'b1;
    end
  end
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      state <= N'(1);
      f <= '0;
      cnt <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= N'(1) << nf;
      f <= nf;
      cnt <= ncnt;
      wrap <= nwrap;
      err <= nerr;
    end
  end
endmodule
